// File: rtl/window_scheduler.sv
// window_scheduler: frame-level controller between the window-position
// generator and a bank of NUM_ENG classifier engines.
//
// On start, pulls hop coordinates over a valid/ready stream, dispatches each
// window round-robin to an idle engine, retires engine results round-robin
// and forwards the coordinates of positive windows on a single-entry
// detection stream. frame_done pulses once all windows are classified and
// every detection has been delivered.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    frame start pulse (ignored outside IDLE)
//   busy                     high while not IDLE
//   frame_done               one-cycle pulse at end of frame
//   hop_valid/hop_ready      hop coordinate stream, x_hop/y_hop payload
//   eng_start[NUM_ENG]       one-cycle start pulse per engine
//   eng_x/eng_y              per-engine window origin, slice i for engine i
//   res_valid/res_detect     per-engine result, held until res_ack
//   res_ack[NUM_ENG]         same-cycle result acknowledge
//   det_valid/det_ready      detection stream, det_x/det_y payload
//   det_count                (WIN_SCHED_STATS_EN only) positives this frame
//
// Optional feature macro: WIN_SCHED_STATS_EN adds the det_count output.

module window_scheduler #(
    parameter int unsigned IMG_WIDTH  = 41,
    parameter int unsigned IMG_HEIGHT = 50,
    parameter int unsigned SWEEP_X    = 24,
    parameter int unsigned SWEEP_Y    = 24,
    parameter int unsigned NUM_ENG    = 4,
    localparam int unsigned W_X   = $clog2(IMG_WIDTH),
    localparam int unsigned W_Y   = $clog2(IMG_HEIGHT),
    localparam int unsigned TOTAL = (IMG_WIDTH - SWEEP_X) * (IMG_HEIGHT - SWEEP_Y),
    localparam int unsigned W_CNT = $clog2(TOTAL + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   frame_done,
    input  logic                   hop_valid,
    output logic                   hop_ready,
    input  logic [W_X-1:0]         x_hop,
    input  logic [W_Y-1:0]         y_hop,
    output logic [NUM_ENG-1:0]     eng_start,
    output logic [NUM_ENG*W_X-1:0] eng_x,
    output logic [NUM_ENG*W_Y-1:0] eng_y,
    input  logic [NUM_ENG-1:0]     res_valid,
    input  logic [NUM_ENG-1:0]     res_detect,
    output logic [NUM_ENG-1:0]     res_ack,
    output logic                   det_valid,
    input  logic                   det_ready,
    output logic [W_X-1:0]         det_x,
`ifdef WIN_SCHED_STATS_EN
    output logic [W_Y-1:0]         det_y,
    output logic [W_CNT-1:0]       det_count
`else
    output logic [W_Y-1:0]         det_y
`endif
);

    localparam int unsigned W_PTR = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_ENG-1:0] eng_busy;
    logic [W_PTR-1:0]   disp_ptr;
    logic [W_PTR-1:0]   ret_ptr;
    logic [W_CNT-1:0]   issued;
    logic [W_X-1:0]     win_x [NUM_ENG];
    logic [W_Y-1:0]     win_y [NUM_ENG];

    logic               grant_any;
    logic [W_PTR-1:0]   grant_idx;
    logic               ret_any;
    logic [W_PTR-1:0]   ret_idx;
    logic               ret_accept;
    logic               ret_positive;
    logic               hop_fire;
    logic               det_pop;

    // Modulo-NUM_ENG pointer add; NUM_ENG need not be a power of two.
    function automatic logic [W_PTR-1:0] ptr_add(input logic [W_PTR-1:0] base,
                                                 input logic [W_PTR-1:0] off);
        logic [W_PTR:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (W_PTR+1)'(NUM_ENG)) begin
            sum = sum - (W_PTR+1)'(NUM_ENG);
        end
        return sum[W_PTR-1:0];
    endfunction

    // First idle engine at or after the dispatch pointer.
    always_comb begin : dispatch_select
        logic [W_PTR-1:0] idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
            idx = ptr_add(disp_ptr, W_PTR'(k));
            if (!grant_any && !eng_busy[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // First busy engine with a pending result at or after the retire pointer.
    always_comb begin : retire_select
        logic [W_PTR-1:0] idx;
        ret_any = 1'b0;
        ret_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
            idx = ptr_add(ret_ptr, W_PTR'(k));
            if (!ret_any && eng_busy[idx] && res_valid[idx]) begin
                ret_any = 1'b1;
                ret_idx = idx;
            end
        end
    end

    assign det_pop      = det_valid && det_ready;
    // A positive result may only retire when the det slot is free or draining now.
    assign ret_accept   = ret_any && (!res_detect[ret_idx] || !det_valid || det_pop);
    assign ret_positive = ret_accept && res_detect[ret_idx];
    assign hop_fire     = hop_valid && hop_ready;

    always_comb begin : ack_decode
        res_ack = '0;
        if (ret_accept) begin
            res_ack[ret_idx] = 1'b1;
        end
    end

    // FSM next state and stream-ready.
    always_comb begin : fsm_comb
        state_nxt = state;
        hop_ready = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                hop_ready = grant_any && (issued < W_CNT'(TOTAL));
                if (issued == W_CNT'(TOTAL)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((eng_busy == '0) && !det_valid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, dispatch, retire and detection registers.
    always_ff @(posedge clk) begin : main_regs
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            eng_busy   <= '0;
            disp_ptr   <= '0;
            ret_ptr    <= '0;
            issued     <= '0;
            eng_start  <= '0;
            det_valid  <= 1'b0;
            det_x      <= '0;
            det_y      <= '0;
            for (int unsigned i = 0; i < NUM_ENG; i++) begin
                win_x[i] <= '0;
                win_y[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != S_IDLE);
            frame_done <= (state_nxt == S_DONE);
            eng_start  <= '0;

            if ((state == S_IDLE) && start) begin
                issued <= '0;
            end

            if (hop_fire) begin
                eng_busy[grant_idx]  <= 1'b1;
                eng_start[grant_idx] <= 1'b1;
                win_x[grant_idx]     <= x_hop;
                win_y[grant_idx]     <= y_hop;
                disp_ptr             <= ptr_add(grant_idx, W_PTR'(1));
                issued               <= issued + W_CNT'(1);
            end

            // grant_idx is never busy and ret_idx always is, so they never collide.
            if (ret_accept) begin
                eng_busy[ret_idx] <= 1'b0;
                ret_ptr           <= ptr_add(ret_idx, W_PTR'(1));
            end

            if (ret_positive) begin
                det_valid <= 1'b1;
                det_x     <= win_x[ret_idx];
                det_y     <= win_y[ret_idx];
            end else if (det_pop) begin
                det_valid <= 1'b0;
            end
        end
    end

    // Expose the latched windows as flat per-engine slices.
    for (genvar g = 0; g < NUM_ENG; g++) begin : g_eng_out
        assign eng_x[g*W_X +: W_X] = win_x[g];
        assign eng_y[g*W_Y +: W_Y] = win_y[g];
    end

`ifdef WIN_SCHED_STATS_EN
    // Positive results accepted since the last start; holds after frame_done.
    always_ff @(posedge clk) begin : stats_regs
        if (rst) begin
            det_count <= '0;
        end else if ((state == S_IDLE) && start) begin
            det_count <= '0;
        end else if (ret_positive) begin
            det_count <= det_count + W_CNT'(1);
        end
    end
`endif

endmodule

// File: tb/tb_window_scheduler.sv
// Self-checking bench for window_scheduler (default parameters).
// A behavioural engine bank and hop source drive the DUT; dispatched windows
// and expected detections are queued and matched against DUT outputs.

module tb_window_scheduler;

    localparam int unsigned NUM_ENG = 4;
    localparam int unsigned W_X     = 6;
    localparam int unsigned W_Y     = 6;
    localparam int unsigned W_CNT   = 9;
    localparam int unsigned TOTAL   = 442;
    localparam int unsigned NX      = 17;

    typedef struct packed {
        logic [W_X-1:0] x;
        logic [W_Y-1:0] y;
    } coord_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   busy;
    logic                   frame_done;
    logic                   hop_valid;
    logic                   hop_ready;
    logic [W_X-1:0]         x_hop;
    logic [W_Y-1:0]         y_hop;
    logic [NUM_ENG-1:0]     eng_start;
    logic [NUM_ENG*W_X-1:0] eng_x;
    logic [NUM_ENG*W_Y-1:0] eng_y;
    logic [NUM_ENG-1:0]     res_valid;
    logic [NUM_ENG-1:0]     res_detect;
    logic [NUM_ENG-1:0]     res_ack;
    logic                   det_valid;
    logic                   det_ready;
    logic [W_X-1:0]         det_x;
    logic [W_Y-1:0]         det_y;
`ifdef WIN_SCHED_STATS_EN
    logic [W_CNT-1:0]       det_count;
`endif

    window_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .hop_valid  (hop_valid),
        .hop_ready  (hop_ready),
        .x_hop      (x_hop),
        .y_hop      (y_hop),
        .eng_start  (eng_start),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .res_valid  (res_valid),
        .res_detect (res_detect),
        .res_ack    (res_ack),
        .det_valid  (det_valid),
        .det_ready  (det_ready),
        .det_x      (det_x),
`ifdef WIN_SCHED_STATS_EN
        .det_y      (det_y),
        .det_count  (det_count)
`else
        .det_y      (det_y)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bench model state
    coord_t      hop_q [$];
    coord_t      det_q [$];
    coord_t      ovr_q [$];
    int unsigned start_log [$];
    int unsigned hop_idx;
    bit          hop_en;
    bit          eng_auto;
    bit          dr_random;
    int unsigned det_mode;
    coord_t      held    [NUM_ENG];
    bit          active  [NUM_ENG];
    bit          clr_pend[NUM_ENG];
    bit          ack_seen[NUM_ENG];
    int unsigned cnt     [NUM_ENG];
    int unsigned n_hops, n_starts, n_fd, n_det_pop, n_det_cycles;

    // Values sampled at the falling edge
    logic                   s_busy, s_fd, s_hop_ready, s_det_valid;
    logic [NUM_ENG-1:0]     s_ack, s_eng_start;
    logic [NUM_ENG*W_X-1:0] s_eng_x;
    logic [NUM_ENG*W_Y-1:0] s_eng_y;
    logic [W_X-1:0]         s_det_x;
    logic [W_Y-1:0]         s_det_y;
`ifdef WIN_SCHED_STATS_EN
    logic [W_CNT-1:0]       s_det_count, fd_det_count;
`endif

    function automatic coord_t src_coord();
        coord_t c;
        if (ovr_q.size() > 0) begin
            c = ovr_q[0];
        end else begin
            c.x = W_X'(hop_idx % NX);
            c.y = W_Y'(hop_idx / NX);
        end
        return c;
    endfunction

    function automatic logic detect_rule(input coord_t c);
        return (det_mode == 1) && (c.x == '0);
    endfunction

    task automatic clear_model();
        hop_q.delete(); det_q.delete(); ovr_q.delete(); start_log.delete();
        hop_idx = 0; n_hops = 0; n_starts = 0; n_fd = 0; n_det_pop = 0; n_det_cycles = 0;
        for (int i = 0; i < NUM_ENG; i++) begin
            active[i] = 0; clr_pend[i] = 0; ack_seen[i] = 0; cnt[i] = 0; held[i] = '0;
        end
    endtask

    task automatic sample();
        coord_t c;
        s_busy = busy; s_fd = frame_done; s_hop_ready = hop_ready; s_det_valid = det_valid;
        s_ack = res_ack; s_eng_start = eng_start; s_eng_x = eng_x; s_eng_y = eng_y;
        s_det_x = det_x; s_det_y = det_y;
`ifdef WIN_SCHED_STATS_EN
        s_det_count = det_count;
        if (frame_done) fd_det_count = det_count;
`endif
        for (int i = 0; i < NUM_ENG; i++) begin
            if (eng_start[i]) begin
                n_starts++;
                start_log.push_back(i);
                if (hop_q.size() == 0) begin
                    check_eq("eng_start_unmatched", 32'(eng_start[i]), 0);
                end else begin
                    c = hop_q.pop_front();
                    check_eq("eng_x", 32'(eng_x[i*W_X +: W_X]), 32'(c.x));
                    check_eq("eng_y", 32'(eng_y[i*W_Y +: W_Y]), 32'(c.y));
                    held[i] = c; active[i] = 1; cnt[i] = 3;
                end
            end
            if (res_ack[i]) begin
                check_eq("ack_without_valid", 32'(res_valid[i]), 1);
                ack_seen[i] = 1; clr_pend[i] = 1; active[i] = 0;
                if (res_detect[i]) det_q.push_back(held[i]);
            end
        end
        if ($countones(res_ack) > 1) check_eq("ack_multi", $countones(res_ack), 1);
        if (hop_valid && hop_ready) begin
            hop_q.push_back(src_coord());
            n_hops++;
            if (ovr_q.size() > 0) void'(ovr_q.pop_front());
            else hop_idx++;
        end
        if (det_valid) n_det_cycles++;
        if (det_valid && det_ready) begin
            n_det_pop++;
            if (det_q.size() == 0) begin
                check_eq("det_unmatched", 32'(det_valid), 0);
            end else begin
                c = det_q.pop_front();
                check_eq("det_x", 32'(det_x), 32'(c.x));
                check_eq("det_y", 32'(det_y), 32'(c.y));
            end
        end
        if (frame_done) n_fd++;
    endtask

    task automatic drive();
        coord_t c;
        c = src_coord();
        hop_valid = hop_en; x_hop = c.x; y_hop = c.y;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (clr_pend[i]) begin
                res_valid[i] = 1'b0; res_detect[i] = 1'b0; clr_pend[i] = 0;
            end else if (eng_auto && active[i] && !res_valid[i]) begin
                if (cnt[i] > 0) cnt[i]--;
                if (cnt[i] == 0) begin
                    res_valid[i]  = 1'b1;
                    res_detect[i] = detect_rule(held[i]);
                end
            end
        end
        if (dr_random) det_ready = 1'($urandom_range(0, 1));
    endtask

    // One clock: sample at the falling edge, update inputs just after the rising edge.
    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic reset_dut();
        rst = 1'b1; start = 1'b0; hop_valid = 1'b0; res_valid = '0; res_detect = '0;
        det_ready = 1'b0; hop_en = 0; eng_auto = 0; dr_random = 0; det_mode = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},       32'(s_busy), 0);
        check_eq({tag, "_frame_done"}, 32'(s_fd), 0);
        check_eq({tag, "_hop_ready"},  32'(s_hop_ready), 0);
        check_eq({tag, "_eng_start"},  32'(s_eng_start), 0);
        check_eq({tag, "_eng_x"},      32'(s_eng_x), 0);
        check_eq({tag, "_eng_y"},      32'(s_eng_y), 0);
        check_eq({tag, "_res_ack"},    32'(s_ack), 0);
        check_eq({tag, "_det_valid"},  32'(s_det_valid), 0);
        check_eq({tag, "_det_x"},      32'(s_det_x), 0);
        check_eq({tag, "_det_y"},      32'(s_det_y), 0);
`ifdef WIN_SCHED_STATS_EN
        check_eq({tag, "_det_count"},  32'(s_det_count), 0);
`endif
    endtask

    task automatic run_frame(input string tag);
        int unsigned k;
        int unsigned f0;
        k = 0; f0 = n_fd;
        while (n_fd == f0 && k < 6000) begin
            step();
            k++;
        end
        check_eq({tag, "_frame_done"},   n_fd - f0, 1);
        check_eq({tag, "_busy_at_done"}, 32'(s_busy), 1);
        check_eq({tag, "_hops"},         n_hops, TOTAL);
        check_eq({tag, "_starts"},       n_starts, TOTAL);
        step();
        check_eq({tag, "_busy_after"},   32'(s_busy), 0);
        check_eq({tag, "_single_done"},  32'(s_fd), 0);
    endtask

    initial begin
        int unsigned k;
        int unsigned v;
        coord_t c;

        rst = 1'b1; start = 1'b0; hop_valid = 1'b0; x_hop = '0; y_hop = '0;
        res_valid = '0; res_detect = '0; det_ready = 1'b0;
        hop_en = 0; eng_auto = 0; dr_random = 0; det_mode = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check_idle_outputs("reset");

        // Full frame, no detections
        eng_auto = 1; det_ready = 1'b1; hop_en = 1;
        start_pulse();
        run_frame("plain");
        check_eq("plain_det_valid_cycles", n_det_cycles, 0);

        // All engines stall: strict round-robin fill, then backpressure
        reset_dut();
        det_ready = 1'b1; hop_en = 1;
        start_pulse();
        repeat (8) step();
        check_eq("stall_count", start_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            v = (start_log.size() > i) ? start_log[i] : 99;
            check_eq("stall_order", v, i);
        end
        check_eq("stall_hop_ready", 32'(s_hop_ready), 0);
        res_valid[2] = 1'b1; res_detect[2] = 1'b0;
        k = 0;
        while (!ack_seen[2] && k < 10) begin step(); k++; end
        check_eq("release_ack2", 32'(ack_seen[2]), 1);
        k = 0;
        while (start_log.size() < 5 && k < 10) begin step(); k++; end
        v = (start_log.size() > 4) ? start_log[4] : 99;
        check_eq("redispatch_engine", v, 2);

        // Simultaneous results from engines 0 and 2 retire one per cycle
        res_valid[0] = 1'b1; res_valid[2] = 1'b1; res_detect[0] = 1'b0; res_detect[2] = 1'b0;
        step();
        check_eq("rr_ack_first", 32'(s_ack), 32'h1);
        step();
        check_eq("rr_ack_second", 32'(s_ack), 32'h4);
        eng_auto = 1;
        run_frame("stall");

        // Detection held under backpressure, second positive blocked
        reset_dut();
        c.x = 1; c.y = 1; ovr_q.push_back(c);
        c.x = 5; c.y = 7; ovr_q.push_back(c);
        c.x = 2; c.y = 2; ovr_q.push_back(c);
        c.x = 9; c.y = 3; ovr_q.push_back(c);
        det_ready = 1'b0; hop_en = 1;
        start_pulse();
        repeat (8) step();
        res_valid[1] = 1'b1; res_detect[1] = 1'b1;
        step();
        check_eq("det1_ack", 32'(s_ack), 32'h2);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("det_hold_valid", 32'(s_det_valid), 1);
            check_eq("det_hold_x", 32'(s_det_x), 5);
            check_eq("det_hold_y", 32'(s_det_y), 7);
        end
        res_valid[3] = 1'b1; res_detect[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("det3_blocked", 32'(s_ack[3]), 0);
        end
        check_eq("no_early_done", n_fd, 0);
        det_ready = 1'b1;
        step();
        check_eq("det3_ack_on_pop", 32'(s_ack), 32'h8);
        step();
        check_eq("det3_valid", 32'(s_det_valid), 1);
        eng_auto = 1;
        run_frame("detect");
        check_eq("detect_pops", n_det_pop, 2);
        check_eq("detect_leftover", det_q.size(), 0);

        // Reset mid-frame abandons the frame; a new frame runs to completion
        reset_dut();
        eng_auto = 1; det_ready = 1'b1; hop_en = 1;
        start_pulse();
        k = 0;
        while (n_starts < 100 && k < 2000) begin step(); k++; end
        check_eq("mid_dispatches", n_starts, 100);
        reset_dut();
        step();
        check_idle_outputs("midrst");
        eng_auto = 1; det_ready = 1'b1; hop_en = 1;
        start_pulse();
        run_frame("after_rst");

        // Positives on every x==0 window with a random consumer
        reset_dut();
        eng_auto = 1; det_mode = 1; dr_random = 1; det_ready = 1'b1; hop_en = 1;
        start_pulse();
        run_frame("stats");
        check_eq("stats_pops", n_det_pop, 26);
        check_eq("stats_leftover", det_q.size(), 0);
`ifdef WIN_SCHED_STATS_EN
        check_eq("det_count_at_done", 32'(fd_det_count), 26);
        check_eq("det_count_held", 32'(s_det_count), 26);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
